alt_vipcti_sync_qualified: RTL

ALT_VIPCTI_SYNC_QUALIFIED -- requirements
Module: alt_vipcti_sync_qualified

---
 rtl/alt_vipcti_sync_qualified_pkg.sv | 24 ++
 rtl/alt_vipcti_sync_chain.sv | 40 ++++
 rtl/alt_vipcti_sync_qualified.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alt_vipcti_sync_qualified_pkg.sv
// Shared definitions for the qualified synchroniser: parameter ranges,
// qualifier state encoding and a constant clog2 helper.
package alt_vipcti_sync_qualified_pkg;

  localparam int unsigned WIDTH_MIN         = 1;
  localparam int unsigned WIDTH_MAX         = 64;
  localparam int unsigned STAGES_MIN        = 2;
  localparam int unsigned STAGES_MAX        = 4;
  localparam int unsigned STABLE_CYCLES_MAX = 255;

  typedef enum logic {
    SETTLING = 1'b0,
    STABLE   = 1'b1
  } sync_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/alt_vipcti_sync_chain.sv
// Multi-flop synchroniser chain for an asynchronous bus.
// Ports:
//   sync_clock - destination clock, rising edge
//   rst        - asynchronous active-high reset, loads RESET_VALUE
//   data_in    - asynchronous source bus
//   data_out   - output of the last chain stage
module alt_vipcti_sync_chain
  import alt_vipcti_sync_qualified_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             sync_clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("alt_vipcti_sync_chain: STAGES=%0d out of range", STAGES);
  end

  // Tagged so timing analysis treats these as metastability-hardening flops.
  (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
  logic [WIDTH-1:0] chain [STAGES];

  // Shift register; stage 0 is the only flop sampling the async domain.
  always_ff @(posedge sync_clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) chain[i] <= RESET_VALUE;
    end else begin
      chain[0] <= data_in;
      for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
    end
  end

  assign data_out = chain[STAGES-1];

endmodule

// File: rtl/alt_vipcti_sync_qualified.sv
// Bus synchroniser with optional stability qualification and edge pulses.
// A new synchronised value is published on data_out only after it has been
// sampled unchanged on STABLE_CYCLES consecutive edges.
// Ports:
//   sync_clock - destination clock, rising edge
//   rst        - asynchronous active-high reset
//   data_in    - asynchronous source bus
//   data_out   - synchronised, qualified bus
//   rise_pulse - per-bit one-cycle pulse on a 0->1 change of data_out
//   fall_pulse - per-bit one-cycle pulse on a 1->0 change of data_out
//   changed    - one-cycle pulse when any data_out bit changes
//   stable     - high when no change is pending qualification
module alt_vipcti_sync_qualified
  import alt_vipcti_sync_qualified_pkg::*;
#(
  parameter int unsigned      CLOCKS_ARE_SAME = 0,
  parameter int unsigned      WIDTH           = 1,
  parameter int unsigned      STAGES          = 2,
  parameter int unsigned      STABLE_CYCLES   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             sync_clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed,
  output logic             stable
);

  localparam int unsigned CNT_W_RAW = clog2(STABLE_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;

  if (CLOCKS_ARE_SAME > 1) begin : g_bad_same
    $error("alt_vipcti_sync_qualified: CLOCKS_ARE_SAME=%0d illegal", CLOCKS_ARE_SAME);
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("alt_vipcti_sync_qualified: WIDTH=%0d out of range", WIDTH);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("alt_vipcti_sync_qualified: STAGES=%0d out of range", STAGES);
  end
  if (STABLE_CYCLES > STABLE_CYCLES_MAX) begin : g_bad_cycles
    $error("alt_vipcti_sync_qualified: STABLE_CYCLES=%0d out of range", STABLE_CYCLES);
  end

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] data_out_d;

  // Synchroniser, or a straight wire when source and destination share a clock.
  if (CLOCKS_ARE_SAME != 0) begin : g_bypass
    assign s = data_in;
  end else begin : g_chain
    alt_vipcti_sync_chain #(
      .WIDTH      (WIDTH),
      .STAGES     (STAGES),
      .RESET_VALUE(RESET_VALUE)
    ) u_chain (
      .sync_clock(sync_clock),
      .rst       (rst),
      .data_in   (data_in),
      .data_out  (s)
    );
  end

  if (STABLE_CYCLES == 0) begin : g_no_qual
    assign data_out = s;
    assign stable   = 1'b1;
  end else begin : g_qual
    // The edge that captures a new candidate is its first stable sample, so
    // publication happens when cnt reaches N-2 and cnt then rests at N-1.
    localparam bit               SINGLE      = (STABLE_CYCLES == 1);
    localparam int unsigned      PUBLISH_INT = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_PUBLISH = CNT_W'(PUBLISH_INT);

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] data_out_q;
    logic [CNT_W-1:0] cnt;
    sync_state_e      state;

    // Qualifier FSM: any disagreement restarts qualification of the new value.
    always_ff @(posedge sync_clock or posedge rst) begin
      if (rst) begin
        cand       <= RESET_VALUE;
        data_out_q <= RESET_VALUE;
        cnt        <= '0;
        state      <= STABLE;
      end else if (s != cand) begin
        cand <= s;
        cnt  <= '0;
        if (SINGLE) begin
          data_out_q <= s;
          state      <= STABLE;
        end else begin
          state <= SETTLING;
        end
      end else if (state == SETTLING) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_PUBLISH) begin
          data_out_q <= cand;
          state      <= STABLE;
        end
      end
    end

    assign data_out = data_out_q;
    assign stable   = (state == STABLE);
  end

  // Previous published value, for edge detection.
  always_ff @(posedge sync_clock or posedge rst) begin
    if (rst) data_out_d <= RESET_VALUE;
    else     data_out_d <= data_out;
  end

  assign rise_pulse = data_out & ~data_out_d;
  assign fall_pulse = ~data_out & data_out_d;
  assign changed    = |(data_out ^ data_out_d);

endmodule
